// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: FSM states, access-size encodings
// and the store-lane helpers used when sub-word accesses are enabled.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte enables for a store; size 2'b11 falls through to a full word.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Combinational lane extraction and sign/zero extension of a loaded word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[{offset, 3'b000} +: 8];
    lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: data = {{24{~is_unsigned & lane_byte[7]}}, lane_byte};
      SIZE_HALF: data = {{16{~is_unsigned & lane_half[15]}}, lane_half};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns EX_MEM load/store controls into a stalling dmem handshake.
// Define MEM_SUBWORD_EN to support byte/half accesses; otherwise all accesses are words.
module mem_access_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        regWrite_MEM,
  input  logic        memToReg_MEM,
  input  logic        memRead_MEM,
  input  logic        memWrite_MEM,
  input  logic [31:0] ALUresult_MEM,
  input  logic [31:0] writeData_MEM,
  input  logic [4:0]  writeReg_MEM,
  input  logic [1:0]  memSize_MEM,
  input  logic        memUnsigned_MEM,
  output logic        regWrite_out,
  output logic [31:0] readData_MEM,
  output logic        stall_MEM,
  mem_access_stage_if.master dmem
);

  mem_state_e  state_reg, state_next;
  logic        transfer;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic        we_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_fmt, load_data;
  logic [3:0]  be_fmt;

  assign transfer = memRead_MEM | memWrite_MEM;

`ifdef MEM_SUBWORD_EN
  logic [1:0] size_reg;
  logic       unsigned_reg;
  // memToReg/writeReg travel to MEM_WB alongside this stage, not through it.
  logic       unused_inputs;

  assign unused_inputs = &{1'b0, memToReg_MEM, writeReg_MEM};
  assign be_fmt        = lane_enable(memSize_MEM, ALUresult_MEM[1:0]);
  assign wdata_fmt     = lane_replicate(memSize_MEM, writeData_MEM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && transfer) begin
      size_reg     <= memSize_MEM;
      unsigned_reg <= memUnsigned_MEM;
    end
  end

  load_align u_load_align (
    .rdata       (dmem.dmem_rdata),
    .offset      (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .data        (load_data)
  );
`else
  logic unused_inputs;

  assign unused_inputs = &{1'b0, memToReg_MEM, writeReg_MEM, memSize_MEM,
                           memUnsigned_MEM, addr_reg[1:0]};
  assign be_fmt        = 4'b1111;
  assign wdata_fmt     = writeData_MEM;
  assign load_data     = dmem.dmem_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      we_reg    <= 1'b0;
      be_reg    <= 4'b0000;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && transfer) begin
        addr_reg  <= ALUresult_MEM;
        wdata_reg <= wdata_fmt;
        we_reg    <= memWrite_MEM;
        be_reg    <= be_fmt;
      end
      // A simultaneous read+write is a store, so the load buffer is left alone.
      if (state_reg == ST_REQ && dmem.dmem_ack && !we_reg)
        rdata_reg <= load_data;
    end
  end

  always_comb begin
    state_next    = state_reg;
    stall_MEM     = 1'b0;
    dmem.dmem_req = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          state_next = ST_REQ;
          stall_MEM  = 1'b1;
        end
      end
      ST_REQ: begin
        stall_MEM     = 1'b1;
        dmem.dmem_req = 1'b1;
        if (dmem.dmem_ack)
          state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign dmem.dmem_we    = we_reg & (state_reg == ST_REQ);
  assign dmem.dmem_addr  = {addr_reg[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_reg;
  assign dmem.dmem_be    = be_reg;
  assign readData_MEM    = rdata_reg;
  assign regWrite_out    = regWrite_MEM & ~stall_MEM;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a behavioural memory-stage model.
module tb_mem_access_stage;

`ifdef MEM_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        regWrite_MEM, memToReg_MEM, memRead_MEM, memWrite_MEM;
  logic [31:0] ALUresult_MEM, writeData_MEM;
  logic [4:0]  writeReg_MEM;
  logic [1:0]  memSize_MEM;
  logic        memUnsigned_MEM;
  logic        regWrite_out, stall_MEM;
  logic [31:0] readData_MEM;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_xfers  = 0;
  logic [31:0] exp_rd   = 32'd0;

  mem_access_stage_if dmem_bus ();

  mem_access_stage dut (
    .clk             (clk),
    .rst             (rst),
    .regWrite_MEM    (regWrite_MEM),
    .memToReg_MEM    (memToReg_MEM),
    .memRead_MEM     (memRead_MEM),
    .memWrite_MEM    (memWrite_MEM),
    .ALUresult_MEM   (ALUresult_MEM),
    .writeData_MEM   (writeData_MEM),
    .writeReg_MEM    (writeReg_MEM),
    .memSize_MEM     (memSize_MEM),
    .memUnsigned_MEM (memUnsigned_MEM),
    .regWrite_out    (regWrite_out),
    .readData_MEM    (readData_MEM),
    .stall_MEM       (stall_MEM),
    .dmem            (dmem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Number of bytes an access touches; word when sub-word support is absent.
  function automatic int access_bytes(input logic [1:0] size);
    if (!SUBWORD) return 4;
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic [1:0] size, input logic uns);
    int     n;
    int     base;
    longint v;
    n = access_bytes(size);
    if (n == 4) return rd;
    base = ((addr % 4) / n) * n;
    v = (longint'(rd) >> (8 * base)) % (longint'(1) << (8 * n));
    if (!uns && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic [1:0] size);
    int n;
    int base;
    int m;
    n = access_bytes(size);
    base = ((addr % 4) / n) * n;
    m = ((1 << n) - 1) << base;
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] size);
    int n;
    n = access_bytes(size);
    if (n == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic alu_cycle(input logic rw);
    @(posedge clk); #1;
    regWrite_MEM    = rw;
    memRead_MEM     = 1'b0;
    memWrite_MEM    = 1'b0;
    ALUresult_MEM   = $urandom;
    writeData_MEM   = $urandom;
    dmem_bus.dmem_ack   = 1'($urandom % 2);
    dmem_bus.dmem_rdata = $urandom;
    @(negedge clk);
    check("alu_stall", 32'(stall_MEM), 32'd0);
    check("alu_wb", 32'(regWrite_out), 32'(rw));
    check("alu_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("alu_rdata", readData_MEM, exp_rd);
  endtask

  task automatic do_xfer(input logic rd, input logic wr, input logic rw,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input logic uns,
                         input int waits, input logic [31:0] rdata);
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    e_addr  = addr & 32'hFFFF_FFFC;
    e_be    = ref_be(addr, size);
    e_wdata = ref_wdata(wd, size);

    @(posedge clk); #1;
    regWrite_MEM    = rw;
    memRead_MEM     = rd;
    memWrite_MEM    = wr;
    ALUresult_MEM   = addr;
    writeData_MEM   = wd;
    memSize_MEM     = size;
    memUnsigned_MEM = uns;
    writeReg_MEM    = 5'($urandom);
    dmem_bus.dmem_ack   = 1'($urandom % 2);
    dmem_bus.dmem_rdata = $urandom;
    @(negedge clk);
    check("idle_stall", 32'(stall_MEM), 32'd1);
    check("idle_wb", 32'(regWrite_out), 32'd0);
    check("idle_req", 32'(dmem_bus.dmem_req), 32'd0);

    for (int k = 0; k <= waits; k++) begin
      @(posedge clk); #1;
      dmem_bus.dmem_ack   = (k == waits);
      dmem_bus.dmem_rdata = (k == waits) ? rdata : $urandom;
      @(negedge clk);
      check("req_req", 32'(dmem_bus.dmem_req), 32'd1);
      check("req_we", 32'(dmem_bus.dmem_we), 32'(wr));
      check("req_addr", dmem_bus.dmem_addr, e_addr);
      if (wr) begin
        check("req_be", 32'(dmem_bus.dmem_be), 32'(e_be));
        check("req_wdata", dmem_bus.dmem_wdata, e_wdata);
      end
      check("req_stall", 32'(stall_MEM), 32'd1);
      check("req_wb", 32'(regWrite_out), 32'd0);
    end
    if (rd && !wr) exp_rd = ref_load(rdata, addr, size, uns);

    @(posedge clk); #1;
    dmem_bus.dmem_ack   = 1'($urandom % 2);
    dmem_bus.dmem_rdata = $urandom;
    @(negedge clk);
    check("done_stall", 32'(stall_MEM), 32'd0);
    check("done_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("done_wb", 32'(regWrite_out), 32'(rw));
    check("done_rdata", readData_MEM, exp_rd);
    n_xfers++;
    $display("xfer %0d: rd=%0d wr=%0d addr=%08h size=%0d uns=%0d waits=%0d readData=%08h",
             n_xfers, rd, wr, addr, size, uns, waits, readData_MEM);
  endtask

  initial begin
    rst = 1'b1;
    regWrite_MEM = 1'b0; memToReg_MEM = 1'b0; memRead_MEM = 1'b0; memWrite_MEM = 1'b0;
    ALUresult_MEM = 32'd0; writeData_MEM = 32'd0; writeReg_MEM = 5'd0;
    memSize_MEM = 2'd2; memUnsigned_MEM = 1'b0;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'd0;
    #12;
    check("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
    check("rst_addr", dmem_bus.dmem_addr, 32'd0);
    check("rst_be", 32'(dmem_bus.dmem_be), 32'd0);
    check("rst_rdata", readData_MEM, 32'd0);
    check("rst_stall", 32'(stall_MEM), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU op with no memory transfer passes straight through.
    alu_cycle(1'b1);
    // Word load with same-cycle ack.
    do_xfer(1'b1, 1'b0, 1'b1, 32'h100, 32'd0, 2'd2, 1'b0, 0, 32'hDEAD_BEEF);
    check("load_const", readData_MEM, 32'hDEAD_BEEF);
    alu_cycle(1'b0);
    // Word store with four wait states.
    do_xfer(1'b0, 1'b1, 1'b0, 32'h204, 32'h0000_00AB, 2'd2, 1'b0, 4, 32'h0);
    // Read+write together behaves as a store; load buffer keeps DEADBEEF.
    do_xfer(1'b1, 1'b1, 1'b1, 32'h308, 32'h5555_AAAA, 2'd2, 1'b0, 1, 32'h1234_5678);
    check("rdwr_keep", readData_MEM, 32'hDEAD_BEEF);

`ifdef MEM_SUBWORD_EN
    do_xfer(1'b1, 1'b0, 1'b1, 32'h103, 32'd0, 2'd0, 1'b0, 0, 32'h80FF_FF7F);
    check("lb_const", readData_MEM, 32'hFFFF_FF80);
    do_xfer(1'b1, 1'b0, 1'b1, 32'h103, 32'd0, 2'd0, 1'b1, 0, 32'h80FF_FF7F);
    check("lbu_const", readData_MEM, 32'h0000_0080);
    do_xfer(1'b0, 1'b1, 1'b0, 32'h102, 32'h0000_1234, 2'd1, 1'b0, 0, 32'h0);
`endif

    // Reset while a load is outstanding abandons it; a late ack is ignored.
    @(posedge clk); #1;
    memRead_MEM = 1'b1; memWrite_MEM = 1'b0; ALUresult_MEM = 32'h440;
    dmem_bus.dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", 32'(dmem_bus.dmem_req), 32'd1);
    #1;
    rst = 1'b1;
    memRead_MEM = 1'b0;
    #1;
    check("mid_rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("mid_rst_we", 32'(dmem_bus.dmem_we), 32'd0);
    check("mid_rst_addr", dmem_bus.dmem_addr, 32'd0);
    check("mid_rst_wdata", dmem_bus.dmem_wdata, 32'd0);
    check("mid_rst_be", 32'(dmem_bus.dmem_be), 32'd0);
    check("mid_rst_rdata", readData_MEM, 32'd0);
    exp_rd = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_ack_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("late_ack_stall", 32'(stall_MEM), 32'd0);
    check("late_ack_rdata", readData_MEM, 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic rd_r, wr_r;
      int   kind;
      kind = $urandom_range(0, 4);
      rd_r = (kind <= 1) || (kind == 4);
      wr_r = (kind == 2) || (kind == 3) || (kind == 4);
      do_xfer(rd_r, wr_r, 1'($urandom % 2), $urandom, $urandom,
              2'($urandom % 4), 1'($urandom % 2), $urandom_range(0, 5), $urandom);
      for (int j = $urandom_range(0, 2); j > 0; j--)
        alu_cycle(1'($urandom % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 rising-edge clock; rst in 1 reset, asynchronous, active-high.
REQ-002 SHALL have control inputs, 1 bit each, from EX_MEM register: regWrite_MEM (write-back enable), memToReg_MEM (select load data), memRead_MEM (load), memWrite_MEM (store).
REQ-003 SHALL have data inputs from EX_MEM register: ALUresult_MEM in 32 (address/result); writeData_MEM in 32 (store data); writeReg_MEM in 5 (destination); memSize_MEM in 2 (00 byte, 01 half, 10 word); memUnsigned_MEM in 1 (zero-extend loads).
REQ-004 SHALL drive outputs to MEM_WB: regWrite_out out 1 (gated write enable); readData_MEM out 32 (load result); stall_MEM out 1 (freeze PC, IF_ID, ID_EX, EX_MEM).
REQ-005 SHALL have data-memory port: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_be out 4; dmem_ack in 1; dmem_rdata in 32.

Function
REQ-006 SHALL implement FSM IDLE, REQ, DONE; transfer = memRead_MEM|memWrite_MEM.
REQ-007 IDLE: transfer=1 -> latch address, store data, we, size, unsigned into internal registers, go REQ; transfer=0 -> stay IDLE, zero added latency.
REQ-008 REQ: dmem_req=1, all dmem_* from latched registers; dmem_ack=1 -> capture aligned load data into readData buffer, go DONE; else remain REQ indefinitely.
REQ-009 DONE: one cycle, unconditionally -> IDLE (inputs still hold completed instruction).
REQ-010 stall_MEM = (IDLE & transfer) | REQ, combinational; 0 in DONE.
REQ-011 regWrite_out = regWrite_MEM & ~stall_MEM.
REQ-012 readData_MEM SHALL be the buffered register; updated only on ack in REQ for loads.
REQ-013 Minimum load/store latency 3 cycles (IDLE, REQ with same-cycle ack, DONE); back-to-back transfers separated by DONE->IDLE.
REQ-014 memRead_MEM and memWrite_MEM both 1: store, read ignored, buffer unchanged.
REQ-015 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-016 dmem_addr SHALL be {addr[31:2],2'b00}; dmem_we=1 only for stores.

Reset
REQ-017 rst asserted, any state including REQ: state IDLE, dmem_req 0, dmem_we 0, dmem_addr/wdata 0, dmem_be 0, readData_MEM 0, latched registers 0; abandoned transfer not resumed.
REQ-018 After rst release, stall_MEM follows REQ-010 from the first edge.

Configuration
REQ-019 Macro MEM_SUBWORD_EN defined: byte/half stores replicate data across lanes, dmem_be one-hot/pair per addr[1:0]; loads extract lane per addr[1:0], sign- or zero-extend per memUnsigned_MEM; memSize 11 treated as word.
REQ-020 MEM_SUBWORD_EN undefined: word access only, dmem_be=4'b1111, dmem_wdata=writeData_MEM, readData=dmem_rdata; memSize_MEM/memUnsigned_MEM ports present but ignored.

Structure
REQ-021 Package mem_stage_pkg SHALL hold FSM state enum and memSize encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
REQ-022 Sub-module load_align (combinational lane extract/extend) SHALL be instantiated only under MEM_SUBWORD_EN.

Verification
REQ-023 ALU op, no transfer, regWrite_MEM=1 -> stall_MEM=0, regWrite_out=1, no dmem_req.
REQ-024 Load addr 0x100, ack same cycle as req, rdata 0xDEADBEEF -> stall 2 cycles, readData_MEM=0xDEADBEEF in DONE, regWrite_out=1 only in DONE.
REQ-025 Store 0x0000_00AB to 0x204 with 4 wait cycles -> dmem_req held 5 cycles, we=1, addr 0x204, stall released at DONE.
REQ-026 MEM_SUBWORD_EN: LB addr 0x103, rdata 0x80FF_FF7F -> 0xFFFF_FF80; LBU -> 0x0000_0080; SH 0x1234 at 0x102 -> be 1100, wdata 0x1234_1234.
REQ-027 rst asserted while in REQ -> next cycle IDLE, dmem_req 0, readData_MEM 0; late ack ignored.
REQ-028 memRead and memWrite both 1 -> store issued, readData_MEM unchanged.
